inverse_2x2_normalize: RTL

Sequential stage downstream of the 2x2 adjugate/valid logic. It accepts a signed 4-bit 2x2 matrix over a valid/ready handshake and computes the determinant. It then divides each adjugate element by the determinant with one shared serial restoring divider, producing the true inverse in signed fixed point (Q with FRAC fractional bits). It flags singular matrices and saturated elements.

---
 rtl/inverse_2x2_normalize.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/inverse_2x2_normalize.sv
// inverse_2x2_normalize
//   Accepts a signed 4-bit 2x2 matrix, computes det and the adjugate, then
//   divides each adjugate element by det with one shared serial restoring
//   divider. Produces the inverse in signed Q(OUT_W-FRAC).FRAC fixed point.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake; in_ready only while idle
//   d11,d12,d21,d22      signed 4-bit matrix elements
//   out_valid/out_ready  result handshake; result held until taken
//   q11,q12,q21,q22      signed OUT_W inverse elements, FRAC fractional bits
//   singular             det == 0 (all q* forced to 0)
//   sat                  at least one q* clipped to the OUT_W range
module inverse_2x2_normalize #(
  parameter int FRAC  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d11,
  input  logic [3:0]       d12,
  input  logic [3:0]       d21,
  input  logic [3:0]       d22,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] q11,
  output logic [OUT_W-1:0] q12,
  output logic [OUT_W-1:0] q21,
  output logic [OUT_W-1:0] q22,
  output logic             singular,
  output logic             sat
);
  localparam int N     = 4 + FRAC;        // quotient bits per element
  localparam int CW    = N + OUT_W;       // wide enough to compare quotient vs range
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DET, S_DIV, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0][3:0]         m_q, m_d;      // [0]=d11 [1]=d12 [2]=d21 [3]=d22
  logic signed [7:0]       det_q, det_d;
  logic [N-1:0]            num_q, num_d;  // numerator shifts out, quotient shifts in
  logic [7:0]              rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              k_q, k_d;
  logic [3:0][OUT_W-1:0]   q_q, q_d;
  logic                    singular_q, singular_d;
  logic                    sat_q, sat_d;

  // Adjugate element k held at 5 bits so that -(-8) is exact.
  function automatic logic signed [4:0] adj(input logic [1:0] k, input logic [3:0][3:0] m);
    logic signed [4:0] t;
    case (k)
      2'd0:    t = $signed({m[3][3], m[3]});
      2'd1:    t = -$signed({m[1][3], m[1]});
      2'd2:    t = -$signed({m[2][3], m[2]});
      default: t = $signed({m[0][3], m[0]});
    endcase
    return t;
  endfunction

  function automatic logic [N-1:0] num_of(input logic signed [4:0] a);
    logic [4:0] mag;
    mag = a[4] ? 5'(-a) : a;
    return {mag[3:0], {FRAC{1'b0}}};
  endfunction

  logic signed [7:0] det_c, p1, p2;
  logic [7:0]        det_abs;
  logic [8:0]        rem_sh;
  logic              ge;
  logic [7:0]        rem_nx;
  logic [N-1:0]      num_nx;
  logic [CW-1:0]     qx, pmax;
  logic              neg, clip;
  logic [OUT_W-1:0]  qval;

  always_comb begin
    p1      = $signed(m_q[0]) * $signed(m_q[3]);
    p2      = $signed(m_q[1]) * $signed(m_q[2]);
    det_c   = p1 - p2;
    det_abs = det_q[7] ? 8'(-det_q) : det_q;
    // one restoring step: shift in next numerator bit, subtract if it fits
    rem_sh  = {rem_q, num_q[N-1]};
    ge      = rem_sh >= {1'b0, det_abs};
    rem_nx  = ge ? 8'(rem_sh - {1'b0, det_abs}) : rem_sh[7:0];
    num_nx  = {num_q[N-2:0], ge};
    // saturation of the just-completed quotient
    qx      = CW'(num_nx);
    pmax    = (CW'(1) << (OUT_W - 1)) - CW'(1);
    neg     = (adj(k_q, m_q) < 0) ^ det_q[7];
    clip    = 1'b0;
    qval    = qx[OUT_W-1:0];
    if (!neg) begin
      if (qx > pmax) begin
        clip = 1'b1;
        qval = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      if (qx > pmax + CW'(1)) begin
        clip = 1'b1;
        qval = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        qval = OUT_W'(-qx[OUT_W-1:0]);  // zero quotient stays +0
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    det_d      = det_q;
    num_d      = num_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    q_d        = q_q;
    singular_d = singular_q;
    sat_d      = sat_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        m_d     = {d22, d21, d12, d11};
        state_d = S_DET;
      end
      S_DET: begin
        det_d = det_c;
        sat_d = 1'b0;
        if (det_c == 8'sd0) begin
          q_d        = '0;
          singular_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          singular_d = 1'b0;
          num_d      = num_of(adj(2'd0, m_q));
          rem_d      = '0;
          cnt_d      = '0;
          k_d        = 2'd0;
          state_d    = S_DIV;
        end
      end
      S_DIV: begin
        num_d = num_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          q_d[k_q] = qval;
          sat_d    = sat_q | clip;
          cnt_d    = '0;
          if (k_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            k_d   = k_q + 2'd1;
            num_d = num_of(adj(k_q + 2'd1, m_q));
            rem_d = '0;
          end
        end
      end
      default: if (out_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      det_q      <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      q_q        <= '0;
      singular_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      det_q      <= det_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      q_q        <= q_d;
      singular_q <= singular_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign q11       = q_q[0];
  assign q12       = q_q[1];
  assign q21       = q_q[2];
  assign q22       = q_q[3];
  assign singular  = singular_q;
  assign sat       = sat_q;
endmodule
